// File: rtl/red_sched.sv
// red_sched: round-robin scheduler sharing one sequential GF(2^m) reduction unit among NUM_REQ clients.
// Optional RUN watchdog when RED_SCHED_TIMEOUT_EN is defined; that build also declares the TIMEOUT parameter.

module red_sched #(
  parameter int DATA_WIDTH = 10,
  parameter int NUM_REQ    = 4,
`ifdef RED_SCHED_TIMEOUT_EN
  parameter int TIMEOUT    = 64,
`endif
  localparam int IDW = $clog2(NUM_REQ),
  localparam int GW  = $clog2(DATA_WIDTH) + 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*GW-1:0]              req_grade,
  input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]  req_poly,
  input  logic [NUM_REQ*2*DATA_WIDTH-1:0]    req_data,
  output logic                               resp_valid,
  input  logic                               resp_ready,
  output logic [IDW-1:0]                     resp_id,
  output logic [DATA_WIDTH-1:0]              resp_data,
  output logic                               resp_err,
  output logic                               red_enable,
  output logic [GW-1:0]                      red_grade,
  output logic [DATA_WIDTH:0]                red_poly,
  output logic [2*DATA_WIDTH-1:0]            red_data,
  input  logic [DATA_WIDTH-1:0]              red_out,
  input  logic                               red_finish,
  output logic                               busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]              state;
  logic [IDW-1:0]          last_grant;
  logic [IDW-1:0]          grant;
  logic                    found;
  int                      idx;
  logic [GW-1:0]           sel_grade;
  logic [DATA_WIDTH:0]     sel_poly;
  logic [2*DATA_WIDTH-1:0] sel_data;
  logic                    bad_grade;

`ifdef RED_SCHED_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt;
`endif

  // Search starts one past the last winner so every requester is served within NUM_REQ jobs.
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      idx = int'(last_grant) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = IDW'(idx);
      end
    end
  end

  assign sel_grade = req_grade[grant*GW +: GW];
  assign sel_poly  = req_poly[grant*(DATA_WIDTH+1) +: DATA_WIDTH+1];
  assign sel_data  = req_data[grant*2*DATA_WIDTH +: 2*DATA_WIDTH];
  assign bad_grade = (sel_grade == '0) || (sel_grade > GW'(DATA_WIDTH));

  // Handshakes: a transfer happens on a rising edge where valid & ready are both high;
  // req_ready depends on req_valid but req_valid never depends on req_ready, and
  // resp_* stay frozen from resp_valid rising until the cycle resp_ready is seen.
  always_comb begin
    req_ready = '0;
    if (state == S_IDLE && found) req_ready[grant] = 1'b1;
  end

  assign busy = (state != S_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      last_grant <= IDW'(NUM_REQ - 1);
      resp_valid <= 1'b0;
      resp_id    <= '0;
      resp_data  <= '0;
      resp_err   <= 1'b0;
      red_enable <= 1'b0;
      red_grade  <= '0;
      red_poly   <= '0;
      red_data   <= '0;
`ifdef RED_SCHED_TIMEOUT_EN
      cnt        <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            last_grant <= grant;
            resp_id    <= grant;
            red_grade  <= sel_grade;
            red_poly   <= sel_poly;
            red_data   <= sel_data;
`ifdef RED_SCHED_TIMEOUT_EN
            cnt        <= '0;
`endif
            if (bad_grade) begin
              // Degrees red cannot handle are answered without ever pulsing red_enable.
              resp_data  <= '0;
              resp_err   <= 1'b1;
              resp_valid <= 1'b1;
              state      <= S_RESP;
            end else begin
              red_enable <= 1'b1;
              state      <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (red_finish) begin
            resp_data  <= red_out;
            resp_err   <= 1'b0;
            resp_valid <= 1'b1;
            red_enable <= 1'b0;
            state      <= S_RESP;
          end
`ifdef RED_SCHED_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT - 1)) begin
            resp_data  <= '0;
            resp_err   <= 1'b1;
            resp_valid <= 1'b1;
            red_enable <= 1'b0;
            state      <= S_RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        S_RESP: begin
          if (resp_ready) begin
            resp_valid <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
